// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer: FSM state encoding and
// the width rule for the retry counter.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // Bits needed to count 0..max_retries inclusive.
    function automatic int retry_w(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer bringing a single asynchronous level into the clk
// domain. The chain clears to 0 on reset so a stale "1" is never reported.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: non-blocking assignments so every stage samples the previous
    // stage's old value on the same edge; blocking would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, waits for a stable synchronized lock, then releases the core
// reset. Lock loss re-resets the PLL; repeated lock timeouts park in FAIL.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pll_locked,
    input  logic                             req_relock,
    output logic                             pll_rst,
    output logic                             core_reset,
    output logic                             ready,
    output logic                             fail,
    output logic [retry_w(MAX_RETRIES)-1:0]  retry_cnt,
    output logic [7:0]                       lost_lock_cnt
);

    localparam int RW = retry_w(MAX_RETRIES);
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

    state_t           state, state_d;
    logic [CNT_W-1:0] timer, timer_d;
    logic [RW-1:0]    retry_d;
    logic [7:0]       lost_d;
    logic             locked_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state;
        timer_d = timer + CNT_W'(1);
        retry_d = retry_cnt;
        lost_d  = lost_lock_cnt;

        unique case (state)
            PLL_RST: begin
                if (timer == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (req_relock) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end else if (locked_s) begin
                    state_d = STABLE;
                end else if (timer == TIMEOUT_LAST) begin
                    retry_d = retry_cnt + RW'(1);
                    state_d = (retry_d == RETRY_MAX) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (req_relock) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end else if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (timer == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (req_relock) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end else if (!locked_s) begin
                    state_d = PLL_RST;
                    lost_d  = (lost_lock_cnt == 8'hFF) ? lost_lock_cnt : lost_lock_cnt + 8'd1;
                end
            end
            FAIL: begin
                if (req_relock) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            default: state_d = PLL_RST;
        endcase

        // RUN and FAIL have no time limit, so the timer parks at zero there.
        if (state_d != state || state_d == RUN || state_d == FAIL) timer_d = '0;
        if (state_d == RUN) retry_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PLL_RST;
            timer         <= '0;
            retry_cnt     <= '0;
            lost_lock_cnt <= '0;
            pll_rst       <= 1'b1;
            core_reset    <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_d;
            timer         <= timer_d;
            retry_cnt     <= retry_d;
            lost_lock_cnt <= lost_d;
            pll_rst       <= (state_d == PLL_RST);
            core_reset    <= (state_d != RUN);
            ready         <= (state_d == RUN);
            fail          <= (state_d == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a timed vector table feeding a
// scoreboard queue, plus hand sequences for async reset and counter saturation.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       req_relock;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] lost_lock_cnt;
    logic [13:0] outs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic        locked;
        logic        relock;
        int          adv;
        logic [13:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        string       name;
        logic [13:0] exp;
    } sb_t;

    sb_t  exp_q[$];
    vec_t tbl[33];

    pll_reset_sequencer #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2),
        .CNT_W               (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .req_relock    (req_relock),
        .pll_rst       (pll_rst),
        .core_reset    (core_reset),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lost_lock_cnt (lost_lock_cnt)
    );

    assign outs = {pll_rst, core_reset, ready, fail, retry_cnt, lost_lock_cnt};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string fmt(input logic [13:0] v);
        return $sformatf("pll_rst=%0b core_reset=%0b ready=%0b fail=%0b retry_cnt=%0d lost_lock_cnt=%0d",
                         v[13], v[12], v[11], v[10], v[9:8], v[7:0]);
    endfunction

    function automatic vec_t mk(input logic l, input logic r, input int adv,
                                input logic p, input logic c, input logic rd, input logic f,
                                input logic [1:0] rc, input logic [7:0] lc);
        vec_t v;
        v.locked = l;
        v.relock = r;
        v.adv    = adv;
        v.exp    = {p, c, rd, f, rc, lc};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s}, expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for ready to reach a level; a timeout shows up as a failed check.
    task automatic wait_ready(input logic val, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (ready === val) break;
            tick(1);
        end
        check(name, ready, val);
    endtask

    // Scoreboard side: compare each expectation at the negedge of its due cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            sb_t e;
            e = exp_q.pop_front();
            check_outputs(e.name, outs, e.exp);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         lk rl adv  prst core rdy fail retry lost
        tbl[0]  = mk(0, 0, 3,  1, 1, 0, 0, 2'd0, 8'd0);  // still in PLL_RST
        tbl[1]  = mk(0, 0, 1,  0, 1, 0, 0, 2'd0, 8'd0);  // 4th edge: WAIT_LOCK
        tbl[2]  = mk(0, 0, 6,  0, 1, 0, 0, 2'd0, 8'd0);
        tbl[3]  = mk(1, 0, 10, 0, 1, 0, 0, 2'd0, 8'd0);  // 10 edges after lock rise
        tbl[4]  = mk(1, 0, 1,  0, 0, 1, 0, 2'd0, 8'd0);  // 11th edge: ready
        tbl[5]  = mk(0, 0, 2,  0, 0, 1, 0, 2'd0, 8'd0);  // lock drop not yet seen
        tbl[6]  = mk(0, 0, 1,  1, 1, 0, 0, 2'd0, 8'd1);  // 3rd edge: PLL re-reset
        tbl[7]  = mk(0, 0, 4,  0, 1, 0, 0, 2'd0, 8'd1);
        tbl[8]  = mk(0, 0, 13, 0, 1, 0, 0, 2'd0, 8'd1);  // lock low 20 cycles total
        tbl[9]  = mk(1, 0, 10, 0, 1, 0, 0, 2'd0, 8'd1);
        tbl[10] = mk(1, 0, 1,  0, 0, 1, 0, 2'd0, 8'd1);
        tbl[11] = mk(0, 0, 3,  1, 1, 0, 0, 2'd0, 8'd2);
        tbl[12] = mk(0, 0, 5,  0, 1, 0, 0, 2'd0, 8'd2);
        tbl[13] = mk(1, 0, 6,  0, 1, 0, 0, 2'd0, 8'd2);  // mid-STABLE
        tbl[14] = mk(0, 0, 3,  0, 1, 0, 0, 2'd0, 8'd2);  // 3-cycle dropout
        tbl[15] = mk(1, 0, 2,  0, 1, 0, 0, 2'd0, 8'd2);  // would be ready without dropout
        tbl[16] = mk(1, 0, 8,  0, 1, 0, 0, 2'd0, 8'd2);
        tbl[17] = mk(1, 0, 1,  0, 0, 1, 0, 2'd0, 8'd2);
        tbl[18] = mk(0, 0, 2,  0, 0, 1, 0, 2'd0, 8'd2);
        tbl[19] = mk(0, 1, 1,  1, 1, 0, 0, 2'd0, 8'd2);  // relock beats lock loss
        tbl[20] = mk(0, 0, 4,  0, 1, 0, 0, 2'd0, 8'd2);
        tbl[21] = mk(0, 0, 31, 0, 1, 0, 0, 2'd0, 8'd2);
        tbl[22] = mk(0, 0, 1,  1, 1, 0, 0, 2'd1, 8'd2);  // first timeout
        tbl[23] = mk(0, 0, 3,  1, 1, 0, 0, 2'd1, 8'd2);
        tbl[24] = mk(0, 0, 1,  0, 1, 0, 0, 2'd1, 8'd2);
        tbl[25] = mk(0, 0, 31, 0, 1, 0, 0, 2'd1, 8'd2);
        tbl[26] = mk(0, 0, 1,  0, 1, 0, 1, 2'd2, 8'd2);  // second timeout: FAIL
        tbl[27] = mk(1, 0, 40, 0, 1, 0, 1, 2'd2, 8'd2);  // FAIL ignores lock
        tbl[28] = mk(1, 1, 1,  1, 1, 0, 0, 2'd0, 8'd2);  // relock out of FAIL
        tbl[29] = mk(1, 0, 3,  1, 1, 0, 0, 2'd0, 8'd2);
        tbl[30] = mk(1, 0, 1,  0, 1, 0, 0, 2'd0, 8'd2);
        tbl[31] = mk(1, 0, 8,  0, 1, 0, 0, 2'd0, 8'd2);
        tbl[32] = mk(1, 0, 1,  0, 0, 1, 0, 2'd0, 8'd2);

        rst_n      = 1'b0;
        pll_locked = 1'b0;
        req_relock = 1'b0;
        #12;
        check_outputs("reset_state", outs, 14'b11_0_0_00_00000000);

        tick(1);
        rst_n = 1'b1;

        for (int i = 0; i < 33; i++) begin
            sb_t e;
            pll_locked = tbl[i].locked;
            req_relock = tbl[i].relock;
            e.due  = cyc + tbl[i].adv;
            e.name = $sformatf("vec%0d", i);
            e.exp  = tbl[i].exp;
            exp_q.push_back(e);
            tick(tbl[i].adv);
        end
        req_relock = 1'b0;

        // Async reset in the middle of STABLE.
        req_relock = 1'b1;
        tick(1);
        req_relock = 1'b0;
        tick(4);
        tick(1);
        tick(3);
        check_outputs("mid_stable", outs, 14'b01_0_0_00_00000010);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("async_reset", outs, 14'b11_0_0_00_00000000);
        tick(2);
        rst_n = 1'b1;
        wait_ready(1'b1, 40, "reset_recover");

        // Repeated lock losses in RUN: the loss counter must stop at 255.
        for (int i = 1; i <= 300; i++) begin
            pll_locked = 1'b0;
            wait_ready(1'b0, 10, "loss_fall");
            pll_locked = 1'b1;
            wait_ready(1'b1, 40, "loss_rise");
            if (i == 254 || i == 255 || i == 300)
                check($sformatf("lost_cnt_%0d", i), lost_lock_cnt, (i > 255) ? 255 : i);
        end
        check("final_retry", retry_cnt, 0);
        check("final_fail", fail, 0);

        tick(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
